uart_time_cmd_parser: RTL and testbench

Byte-stream command parser that sits directly downstream of the UART receiver, consuming its one-cycle data-valid strobe and received byte. Assembles a 5-byte time-set frame (header, hours, minutes, seconds, checksum), validates it, and presents a registered hh:mm:ss value with a one-cycle update strobe to the timekeeping logic. Malformed, out-of-range or stalled frames are discarded and reported with an error strobe and code.

---
 rtl/uart_time_cmd_parser_if.sv | 27 ++
 rtl/uart_time_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_uart_time_cmd_parser.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_time_cmd_parser_if.sv
// Byte-stream and time-output bundle between the UART receiver side and
// the time-set command parser.
interface uart_time_cmd_parser_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_set_valid;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  // Parser side: consumes bytes, produces time and status.
  modport slave (
    input  i_rx_dv, i_rx_byte,
    output o_set_valid, o_hours, o_minutes, o_seconds,
           o_err, o_err_code, o_busy
  );

  // Byte source / time consumer side.
  modport master (
    output i_rx_dv, i_rx_byte,
    input  o_set_valid, o_hours, o_minutes, o_seconds,
           o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/uart_time_cmd_parser.sv
// Assembles HEADER,H,M,S,C time-set frames from the UART byte strobe,
// validates checksum and range, and publishes a registered hh:mm:ss with
// one-cycle accept/error strobes. Stalled frames are dropped by a timeout.
module uart_time_cmd_parser #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter logic [7:0]  HEADER       = 8'h54
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_time_cmd_parser_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_H,
    S_GET_M,
    S_GET_S,
    S_GET_C
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_h, r_m, r_s;
  logic [7:0]    w_h_next, w_m_next, w_s_next;
  logic [4:0]    r_hours, w_hours_next;
  logic [5:0]    r_minutes, w_minutes_next;
  logic [5:0]    r_seconds, w_seconds_next;
  logic          r_set_valid, w_set_valid_next;
  logic          r_err, w_err_next;
  logic [1:0]    r_err_code, w_err_code_next;
  logic          r_busy, w_busy_next;

  logic [7:0]    w_csum;
  logic          w_range_bad;
  logic          w_timeout;

  assign w_csum      = r_h ^ r_m ^ r_s;
  assign w_range_bad = (r_h > 8'd23) || (r_m > 8'd59) || (r_s > 8'd59);
  // A byte on the expiry cycle takes precedence over the timeout.
  assign w_timeout   = (r_state != S_IDLE) && !bus.i_rx_dv && (r_cnt == CNT_LAST);

  // State, shadow and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_h         <= '0;
      r_m         <= '0;
      r_s         <= '0;
      r_hours     <= '0;
      r_minutes   <= '0;
      r_seconds   <= '0;
      r_set_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_h         <= w_h_next;
      r_m         <= w_m_next;
      r_s         <= w_s_next;
      r_hours     <= w_hours_next;
      r_minutes   <= w_minutes_next;
      r_seconds   <= w_seconds_next;
      r_set_valid <= w_set_valid_next;
      r_err       <= w_err_next;
      r_err_code  <= w_err_code_next;
      r_busy      <= w_busy_next;
    end
  end

  // Frame sequencing, evaluation and inter-byte timeout.
  always_comb begin
    w_state_next     = r_state;
    w_h_next         = r_h;
    w_m_next         = r_m;
    w_s_next         = r_s;
    w_hours_next     = r_hours;
    w_minutes_next   = r_minutes;
    w_seconds_next   = r_seconds;
    w_set_valid_next = 1'b0;
    w_err_next       = 1'b0;
    w_err_code_next  = r_err_code;

    if (bus.i_rx_dv || r_state == S_IDLE || w_timeout) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_rx_dv && bus.i_rx_byte == HEADER) begin
          w_state_next = S_GET_H;
        end
      end
      S_GET_H: begin
        if (bus.i_rx_dv) begin
          w_h_next     = bus.i_rx_byte;
          w_state_next = S_GET_M;
        end
      end
      S_GET_M: begin
        if (bus.i_rx_dv) begin
          w_m_next     = bus.i_rx_byte;
          w_state_next = S_GET_S;
        end
      end
      S_GET_S: begin
        if (bus.i_rx_dv) begin
          w_s_next     = bus.i_rx_byte;
          w_state_next = S_GET_C;
        end
      end
      S_GET_C: begin
        if (bus.i_rx_dv) begin
          w_state_next = S_IDLE;
          if (bus.i_rx_byte != w_csum) begin
            w_err_next      = 1'b1;
            w_err_code_next = 2'b01;
          end else if (w_range_bad) begin
            w_err_next      = 1'b1;
            w_err_code_next = 2'b10;
          end else begin
            w_set_valid_next = 1'b1;
            w_hours_next     = r_h[4:0];
            w_minutes_next   = r_m[5:0];
            w_seconds_next   = r_s[5:0];
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_timeout) begin
      w_state_next    = S_IDLE;
      w_err_next      = 1'b1;
      w_err_code_next = 2'b11;
    end

    w_busy_next = (w_state_next != S_IDLE);
  end

  assign bus.o_set_valid = r_set_valid;
  assign bus.o_hours     = r_hours;
  assign bus.o_minutes   = r_minutes;
  assign bus.o_seconds   = r_seconds;
  assign bus.o_err       = r_err;
  assign bus.o_err_code  = r_err_code;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_uart_time_cmd_parser.sv
// Directed bench for the time-set command parser (TIMEOUT_CLKS = 16).
module tb_uart_time_cmd_parser;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  uart_time_cmd_parser_if u_if ();

  uart_time_cmd_parser #(
    .TIMEOUT_CLKS (16),
    .HEADER       (8'h54)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; byte is sampled on the next posedge and the task
  // returns at the following negedge, so consecutive calls are back-to-back.
  task automatic send_byte(input logic [7:0] b);
    u_if.i_rx_dv   = 1'b1;
    u_if.i_rx_byte = b;
    @(negedge clk);
    u_if.i_rx_dv   = 1'b0;
    u_if.i_rx_byte = 8'h00;
    $display("byte %02h -> set_valid=%0b err=%0b code=%0b busy=%0b time=%0d:%0d:%0d",
             b, u_if.o_set_valid, u_if.o_err, u_if.o_err_code, u_if.o_busy,
             u_if.o_hours, u_if.o_minutes, u_if.o_seconds);
  endtask

  task automatic send_frame4(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    send_byte(8'h54);
    send_byte(h);
    send_byte(m);
    send_byte(s);
  endtask

  task automatic check_time(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    check_val({tag, "_h"}, 32'(u_if.o_hours), 32'(h));
    check_val({tag, "_m"}, 32'(u_if.o_minutes), 32'(m));
    check_val({tag, "_s"}, 32'(u_if.o_seconds), 32'(s));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_sv"},   32'(u_if.o_set_valid), 32'd0);
    check_val({tag, "_err"},  32'(u_if.o_err), 32'd0);
    check_val({tag, "_code"}, 32'(u_if.o_err_code), 32'd0);
    check_val({tag, "_busy"}, 32'(u_if.o_busy), 32'd0);
    check_time(tag, 5'd0, 6'd0, 6'd0);
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    u_if.i_rx_dv   = 1'b0;
    u_if.i_rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Valid frame 12:30:45
    send_frame4(8'h0C, 8'h1E, 8'h2D);
    check_val("v1_busy_mid", 32'(u_if.o_busy), 32'd1);
    send_byte(8'h3F);
    check_val("v1_sv", 32'(u_if.o_set_valid), 32'd1);
    check_val("v1_err", 32'(u_if.o_err), 32'd0);
    check_val("v1_busy", 32'(u_if.o_busy), 32'd0);
    check_time("v1", 5'd12, 6'd30, 6'd45);
    @(negedge clk);
    check_val("v1_sv_drop", 32'(u_if.o_set_valid), 32'd0);

    // Bad checksum
    send_frame4(8'h0C, 8'h1E, 8'h2D);
    send_byte(8'h3E);
    check_val("cs_err", 32'(u_if.o_err), 32'd1);
    check_val("cs_code", 32'(u_if.o_err_code), 32'd1);
    check_val("cs_sv", 32'(u_if.o_set_valid), 32'd0);
    check_time("cs", 5'd12, 6'd30, 6'd45);
    @(negedge clk);
    check_val("cs_err_drop", 32'(u_if.o_err), 32'd0);
    check_val("cs_code_hold", 32'(u_if.o_err_code), 32'd1);

    // Range errors: hours 24, minutes 60
    send_frame4(8'h18, 8'h00, 8'h00);
    send_byte(8'h18);
    check_val("rh_err", 32'(u_if.o_err), 32'd1);
    check_val("rh_code", 32'(u_if.o_err_code), 32'd2);
    send_frame4(8'h00, 8'h3C, 8'h00);
    send_byte(8'h3C);
    check_val("rm_err", 32'(u_if.o_err), 32'd1);
    check_val("rm_code", 32'(u_if.o_err_code), 32'd2);
    check_time("rm", 5'd12, 6'd30, 6'd45);
    @(negedge clk);

    // Timeout: error exactly 16 clocks after the 0C strobe
    send_byte(8'h54);
    send_byte(8'h0C);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check_val("to_early", 32'(u_if.o_err), 32'd0);
        check_val("to_busy_pre", 32'(u_if.o_busy), 32'd1);
      end
    end
    @(negedge clk);
    check_val("to_err", 32'(u_if.o_err), 32'd1);
    check_val("to_code", 32'(u_if.o_err_code), 32'd3);
    check_val("to_busy", 32'(u_if.o_busy), 32'd0);
    $display("timeout -> err=%0b code=%0b busy=%0b", u_if.o_err, u_if.o_err_code, u_if.o_busy);
    @(negedge clk);
    send_frame4(8'h01, 8'h02, 8'h03);
    send_byte(8'h00);
    check_val("to_next_sv", 32'(u_if.o_set_valid), 32'd1);
    check_time("to_next", 5'd1, 6'd2, 6'd3);

    // Byte on expiry cycle wins, frame completes as 12:30:45
    send_byte(8'h54);
    send_byte(8'h0C);
    repeat (15) @(negedge clk);
    send_byte(8'h1E);
    check_val("exp_err", 32'(u_if.o_err), 32'd0);
    check_val("exp_busy", 32'(u_if.o_busy), 32'd1);
    send_byte(8'h2D);
    send_byte(8'h3F);
    check_val("exp_sv", 32'(u_if.o_set_valid), 32'd1);
    check_time("exp", 5'd12, 6'd30, 6'd45);

    // Idle garbage is ignored silently
    send_byte(8'h41);
    send_byte(8'h00);
    send_byte(8'hFF);
    check_val("idle_sv", 32'(u_if.o_set_valid), 32'd0);
    check_val("idle_err", 32'(u_if.o_err), 32'd0);
    check_val("idle_busy", 32'(u_if.o_busy), 32'd0);

    // Header bytes inside the payload are data
    send_frame4(8'h54, 8'h00, 8'h00);
    check_val("hdr_busy", 32'(u_if.o_busy), 32'd1);
    send_byte(8'h54);
    check_val("hdr_err", 32'(u_if.o_err), 32'd1);
    check_val("hdr_code", 32'(u_if.o_err_code), 32'd2);
    check_val("hdr_busy_end", 32'(u_if.o_busy), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-frame
    send_byte(8'h54);
    send_byte(8'h0C);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h0C);
    send_byte(8'h1E);
    send_byte(8'h2D);
    send_byte(8'h3F);
    check_all_zero("post_rst");
    @(negedge clk);
    check_val("post_rst_sv2", 32'(u_if.o_set_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
